// File: rtl/game_pkg.sv
// Shared encodings for the breakout mode sequencer: mode codes, field widths,
// button indices and small saturating/stepping helpers.
package game_pkg;

    localparam int MODE_W  = 3;
    localparam int LIVES_W = 2;
    localparam int LEVEL_W = 3;
    localparam int NUM_BTN = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_MENU     = 3'd0,
        MODE_SINGLE   = 3'd1,
        MODE_DUAL     = 3'd2,
        MODE_GAMEOVER = 3'd3,
        MODE_SETUP    = 3'd4,
        MODE_DEMO     = 3'd5
    } mode_e;

    // Bit positions inside btn_n / btn_press ({B5,B4,B3,B2}).
    localparam int BTN_B2 = 0;
    localparam int BTN_B3 = 1;
    localparam int BTN_B4 = 2;
    localparam int BTN_B5 = 3;

    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
        return (lvl == '1) ? lvl : lvl + LEVEL_W'(1);
    endfunction

    function automatic logic [LIVES_W-1:0] lives_cfg_step(input logic [LIVES_W-1:0] cfg);
        return (cfg == LIVES_W'(3)) ? LIVES_W'(1) : cfg + LIVES_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: two-flop synchronizer, stability counter and a
// one-cycle pulse on an accepted press (1->0). Releases are accepted silently.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    // The sample has differed from the accepted level for DEB_CYCLES samples.
    assign accept = (sync2_q != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync1 -> sync2 a real two-stage pipeline.
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            press_q <= accept && !sync2_q;
            if (sync2_q == deb_q || accept) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (accept) begin
                deb_q <= sync2_q;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/game_mode_ctrl.sv
// Breakout mode sequencer: button debounce, screen/mode FSM, lives/level and
// frame-aligned renderer select. `define ATTRACT_DEMO_EN adds the idle attract demo.
module game_mode_ctrl
    import game_pkg::*;
#(
    parameter int DEB_CYCLES      = 500000,
    parameter int LIVES_DEFAULT   = 3,
    parameter int GAMEOVER_FRAMES = 300,
    parameter int IDLE_FRAMES     = 600
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   btn_n,
    input  logic         v_sync,
    input  logic         lose,
    input  logic         level_clear,
    output logic [2:0]   mode,
    output logic [3:0]   btn_press,
    output logic         game_run,
    output logic         game_rst,
    output logic         paused,
    output logic [1:0]   lives,
    output logic [2:0]   level,
    output logic         src_sel
);

    localparam int GO_W = (GAMEOVER_FRAMES > 1) ? $clog2(GAMEOVER_FRAMES) : 1;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_n_i (btn_n[i]),
            .press_o (btn_press[i])
        );
    end

    mode_e               mode_q;
    logic [LIVES_W-1:0]  lives_q;
    logic [LIVES_W-1:0]  lives_cfg_q;
    logic [LEVEL_W-1:0]  level_q;
    logic                paused_q;
    logic                game_rst_q;
    logic                src_sel_q;
    logic [GO_W-1:0]     go_cnt_q;
    logic                vs_q;
    logic                lose_q;
    logic                clear_q;

    logic frame_tick;
    logic lose_edge;
    logic clear_edge;
    logic in_play;
    logic last_life_lost;
    logic go_expired;

    assign frame_tick     = vs_q && !v_sync;
    assign lose_edge      = lose && !lose_q;
    assign clear_edge     = level_clear && !clear_q;
    assign in_play        = (mode_q == MODE_SINGLE) || (mode_q == MODE_DUAL) || (mode_q == MODE_DEMO);
    assign last_life_lost = !paused_q && lose_edge && (lives_q == LIVES_W'(1));
    assign go_expired     = frame_tick && (go_cnt_q == GO_W'(GAMEOVER_FRAMES - 1));

`ifdef ATTRACT_DEMO_EN
    localparam int IDLE_W = (IDLE_FRAMES > 1) ? $clog2(IDLE_FRAMES) : 1;
    logic [IDLE_W-1:0] idle_cnt_q;
`else
    logic unused_idle_frames;
    assign unused_idle_frames = (IDLE_FRAMES != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_MENU;
            lives_q     <= '0;
            lives_cfg_q <= LIVES_W'(LIVES_DEFAULT);
            level_q     <= '0;
            paused_q    <= 1'b0;
            game_rst_q  <= 1'b0;
            src_sel_q   <= 1'b0;
            go_cnt_q    <= '0;
            vs_q        <= 1'b1;
            lose_q      <= 1'b0;
            clear_q     <= 1'b0;
`ifdef ATTRACT_DEMO_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: game_rst defaults low every cycle, so any branch setting it yields a one-cycle pulse.
            game_rst_q <= 1'b0;
            vs_q       <= v_sync;
            lose_q     <= lose;
            clear_q    <= level_clear;

            // Renderer only switches at frame start to avoid tearing.
            if (frame_tick) begin
                src_sel_q <= in_play;
            end

`ifdef ATTRACT_DEMO_EN
            if (mode_q != MODE_MENU) begin
                idle_cnt_q <= '0;
            end
`endif

            case (mode_q)
                MODE_MENU: begin
                    if (btn_press[BTN_B2]) begin
                        mode_q     <= MODE_SINGLE;
                        lives_q    <= lives_cfg_q;
                        level_q    <= '0;
                        paused_q   <= 1'b0;
                        game_rst_q <= 1'b1;
                    end else if (btn_press[BTN_B5]) begin
                        mode_q     <= MODE_DUAL;
                        lives_q    <= lives_cfg_q;
                        level_q    <= '0;
                        paused_q   <= 1'b0;
                        game_rst_q <= 1'b1;
                    end else if (btn_press[BTN_B3]) begin
                        mode_q <= MODE_SETUP;
                    end
`ifdef ATTRACT_DEMO_EN
                    if (|btn_press) begin
                        idle_cnt_q <= '0;
                    end else if (frame_tick) begin
                        if (idle_cnt_q == IDLE_W'(IDLE_FRAMES - 1)) begin
                            idle_cnt_q <= '0;
                            mode_q     <= MODE_DEMO;
                            lives_q    <= lives_cfg_q;
                            level_q    <= '0;
                            paused_q   <= 1'b0;
                            game_rst_q <= 1'b1;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                        end
                    end
`endif
                end

                MODE_SINGLE, MODE_DUAL: begin
                    if (!paused_q) begin
                        if (lose_edge) begin
                            if (lives_q == LIVES_W'(1)) begin
                                lives_q  <= '0;
                                mode_q   <= MODE_GAMEOVER;
                                go_cnt_q <= '0;
                            end else begin
                                lives_q    <= lives_q - LIVES_W'(1);
                                game_rst_q <= 1'b1;
                            end
                        end else if (clear_edge) begin
                            level_q    <= level_inc(level_q);
                            game_rst_q <= 1'b1;
                        end
                    end
                    if (mode_q == MODE_SINGLE && btn_press[BTN_B4] && !last_life_lost) begin
                        paused_q <= !paused_q;
                    end
                end

                MODE_GAMEOVER: begin
                    if (btn_press[BTN_B2] || go_expired) begin
                        mode_q   <= MODE_MENU;
                        go_cnt_q <= '0;
                    end else if (frame_tick) begin
                        go_cnt_q <= go_cnt_q + GO_W'(1);
                    end
                end

                MODE_SETUP: begin
                    if (btn_press[BTN_B3]) begin
                        lives_cfg_q <= lives_cfg_step(lives_cfg_q);
                    end
                    if (btn_press[BTN_B2]) begin
                        mode_q <= MODE_MENU;
                    end
                end

`ifdef ATTRACT_DEMO_EN
                MODE_DEMO: begin
                    if (|btn_press) begin
                        mode_q <= MODE_MENU;
                    end else if (lose_edge) begin
                        game_rst_q <= 1'b1;
                    end else if (clear_edge) begin
                        level_q    <= level_inc(level_q);
                        game_rst_q <= 1'b1;
                    end
                end
`endif

                default: begin
                    mode_q <= MODE_MENU;
                end
            endcase
        end
    end

    assign mode     = mode_q;
    assign game_run = in_play && !paused_q;
    assign game_rst = game_rst_q;
    assign paused   = paused_q;
    assign lives    = lives_q;
    assign level    = level_q;
    assign src_sel  = src_sel_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Self-checking bench for game_mode_ctrl: directed scenarios plus random
// button/event/frame actions scored against a transaction-level model.
module tb_game_mode_ctrl;

    localparam int DEB  = 4;
    localparam int GOF  = 3;
    localparam int LDEF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_n = 4'hF;
    logic       v_sync = 1'b1;
    logic       lose = 1'b0;
    logic       level_clear = 1'b0;

    logic [2:0] mode;
    logic [3:0] btn_press;
    logic       game_run;
    logic       game_rst;
    logic       paused;
    logic [1:0] lives;
    logic [2:0] level;
    logic       src_sel;

    always #5 clk = ~clk;

    game_mode_ctrl #(
        .DEB_CYCLES      (DEB),
        .LIVES_DEFAULT   (LDEF),
        .GAMEOVER_FRAMES (GOF),
        .IDLE_FRAMES     (600)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .v_sync      (v_sync),
        .lose        (lose),
        .level_clear (level_clear),
        .mode        (mode),
        .btn_press   (btn_press),
        .game_run    (game_run),
        .game_rst    (game_rst),
        .paused      (paused),
        .lives       (lives),
        .level       (level),
        .src_sel     (src_sel)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse counters sampled mid-cycle.
    int grst_cnt  = 0;
    int press_cnt = 0;
    always @(negedge clk) begin
        if (game_rst)   grst_cnt++;
        if (|btn_press) press_cnt++;
    end

    // Reference model state (modes: 0 menu, 1 single, 2 dual, 3 gameover, 4 setup).
    int m_mode, m_lives, m_level, m_cfg, m_go;
    int m_paused, m_src;
    int exp_grst, exp_press, grst_base, press_base;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int m_in_play();
        return (m_mode == 1 || m_mode == 2) ? 1 : 0;
    endfunction

    function automatic void m_reset();
        m_mode = 0; m_lives = 0; m_level = 0; m_cfg = LDEF; m_go = 0;
        m_paused = 0; m_src = 0;
        exp_grst = 0; exp_press = 0;
    endfunction

    function automatic void m_start(input int md);
        m_mode = md; m_lives = m_cfg; m_level = 0; m_paused = 0;
        exp_grst++;
    endfunction

    function automatic void m_press(input int b);
        exp_press++;
        case (m_mode)
            0: begin
                if (b == 0)      m_start(1);
                else if (b == 3) m_start(2);
                else if (b == 1) m_mode = 4;
            end
            1: if (b == 2) m_paused = 1 - m_paused;
            3: if (b == 0) m_mode = 0;
            4: begin
                if (b == 1) m_cfg = (m_cfg % 3) + 1;
                if (b == 0) m_mode = 0;
            end
            default: ;
        endcase
    endfunction

    function automatic void m_lose();
        if (m_in_play() == 1 && m_paused == 0) begin
            if (m_lives == 1) begin
                m_lives = 0; m_mode = 3; m_go = 0;
            end else begin
                m_lives--; exp_grst++;
            end
        end
    endfunction

    function automatic void m_clear();
        if (m_in_play() == 1 && m_paused == 0) begin
            m_level = (m_level < 7) ? m_level + 1 : 7;
            exp_grst++;
        end
    endfunction

    function automatic void m_frame();
        m_src = m_in_play();
        if (m_mode == 3) begin
            m_go++;
            if (m_go == GOF) m_mode = 0;
        end
    endfunction

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, ".mode"},     int'(mode),     m_mode);
        check({tag, ".lives"},    int'(lives),    m_lives);
        check({tag, ".level"},    int'(level),    m_level);
        check({tag, ".paused"},   int'(paused),   m_paused);
        check({tag, ".game_run"}, int'(game_run), (m_in_play() == 1 && m_paused == 0) ? 1 : 0);
        check({tag, ".src_sel"},  int'(src_sel),  m_src);
        check({tag, ".grst_cnt"}, grst_cnt - grst_base,   exp_grst);
        check({tag, ".press_cnt"}, press_cnt - press_base, exp_press);
        grst_base = grst_cnt;  exp_grst  = 0;
        press_base = press_cnt; exp_press = 0;
    endtask

    task automatic drv_press(input int b);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1 btn_n[b] = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (btn_press[b]) seen = 1'b1;
        end
        check($sformatf("press_seen%0d", b), int'(seen), 1);
        @(posedge clk); #1 btn_n[b] = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    // kind: 0 lose, 1 level_clear, 2 both together
    task automatic drv_event(input int kind);
        @(posedge clk); #1;
        lose        = (kind != 1);
        level_clear = (kind != 0);
        repeat (3) @(posedge clk);
        #1 lose = 1'b0; level_clear = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic drv_frame();
        @(posedge clk); #1 v_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1 v_sync = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_press(input int b);
        drv_press(b); m_press(b); check_state($sformatf("press_b%0d", b + 2));
    endtask

    task automatic do_event(input int kind);
        drv_event(kind);
        if (kind == 1) m_clear(); else m_lose();
        check_state($sformatf("event%0d", kind));
    endtask

    task automatic do_frame();
        drv_frame(); m_frame(); check_state("frame");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, width, base;
        m_reset();

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        check("reset.mode", int'(mode), 0);
        check("reset.btn_press", int'(btn_press), 0);
        check("reset.game_run", int'(game_run), 0);
        check("reset.game_rst", int'(game_rst), 0);
        check("reset.src_sel", int'(src_sel), 0);
        @(posedge clk); #1 rst = 1'b0;
        grst_base = grst_cnt; press_base = press_cnt;
        check_state("post_reset");

        // Debounce: a 3-cycle glitch is rejected.
        @(posedge clk); #1 btn_n[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 btn_n[0] = 1'b1;
        repeat (12) @(posedge clk);
        check_state("glitch");

        // Debounce: 8-cycle hold gives one pulse 6 cycles after the fall; starts SINGLE.
        lat = -1; width = 0;
        @(posedge clk); #1 btn_n[0] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (btn_press[0]) begin
                if (lat < 0) lat = n;
                width++;
            end
            if (n == 8) btn_n[0] = 1'b1;
        end
        check("deb.latency", lat, 2 + DEB);
        check("deb.width", width, 1);
        repeat (10) @(posedge clk);
        m_press(0);
        check_state("start_single");

        // Renderer follows at the next frame start; then lose all lives.
        do_frame();
        do_event(0);
        do_event(0);
        do_event(0);
        do_frame();
        do_press(0);
        do_press(0);

        // Simultaneous lose/clear, then level saturation.
        do_event(2);
        for (int i = 0; i < 8; i++) do_event(1);

        // Pause gates events and game_run.
        do_press(2);
        do_event(0);
        do_press(2);
        do_event(0);
        do_event(0);
        do_press(0);

        // Setup lives_cfg 3->1->2, then DUAL with 2 lives and game-over timeout.
        do_press(1);
        do_press(1);
        do_press(1);
        do_press(0);
        do_press(3);
        do_press(2);
        do_frame();
        do_event(0);
        do_event(0);
        do_frame();
        do_frame();
        do_frame();

        // Asynchronous reset in the middle of a DUAL game.
        do_press(3);
        do_frame();
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_async.mode", int'(mode), 0);
        check("rst_async.lives", int'(lives), 0);
        check("rst_async.level", int'(level), 0);
        check("rst_async.game_run", int'(game_run), 0);
        check("rst_async.game_rst", int'(game_rst), 0);
        check("rst_async.paused", int'(paused), 0);
        check("rst_async.src_sel", int'(src_sel), 0);
        check("rst_async.btn_press", int'(btn_press), 0);
        base = grst_cnt;
        repeat (3) @(posedge clk);
        check("rst_async.no_grst", grst_cnt - base, 0);
        #1 rst = 1'b0;
        m_reset();
        grst_base = grst_cnt; press_base = press_cnt;
        check_state("post_mid_reset");

        // Random actions against the model.
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3)      do_press(r);
            else if (r <= 5) do_event(0);
            else if (r == 6) do_event(1);
            else if (r == 7) do_event(2);
            else             do_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
